// File: rtl/opcap_pkg.sv
// Shared types and constants for the operand capture stage and the comparator it feeds.
// Build option OPCAP_DB_BYPASS_EN (see key_debounce) removes the button debounce counter.
package opcap_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned MODE_W = 2;
   localparam int unsigned LED_W  = 3;
   localparam int unsigned CNT_W  = 24;

   typedef enum logic [1:0] {
      WAIT_A = 2'd0,
      WAIT_B = 2'd1,
      SHOW   = 2'd2
   } state_e;

   localparam logic [LED_W-1:0] LED_WAIT_A = 3'b001;
   localparam logic [LED_W-1:0] LED_WAIT_B = 3'b010;
   localparam logic [LED_W-1:0] LED_SHOW   = 3'b100;

   localparam logic [MODE_W-1:0] MODE_UNSIGNED = 2'b10;
   localparam logic [MODE_W-1:0] MODE_SIGNED   = 2'b11;

   // One-hot LED pattern for a state; unreachable encodings fall back to WAIT_A.
   function automatic logic [LED_W-1:0] state_led_f(input state_e s);
      case (s)
         WAIT_B:  return LED_WAIT_B;
         SHOW:    return LED_SHOW;
         default: return LED_WAIT_A;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Commit-button conditioner: 2-flop synchronizer, level debounce and a one-cycle press pulse.
// Defining OPCAP_DB_BYPASS_EN removes the counter so the synchronized level is used directly.
module key_debounce
   import opcap_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_n_i,
   output logic press_o
);

   if (DB_CYCLES < 32'd2 || DB_CYCLES > 32'h00FF_FFFF) begin : g_bad_db_cycles
      $error("key_debounce: DB_CYCLES out of range");
   end

   logic sync1_q, sync2_q;
   logic stable;
   logic stable_prev_q;
   logic press_q, press_d;

   // Synchronizer resets to the released level so a held key counts only after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef OPCAP_DB_BYPASS_EN
   assign stable = sync2_q;
`else
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 32'd1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;

   // Count consecutive disagreeing samples; any agreeing sample restarts the count.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         stable_q <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;
`endif

   assign press_d = stable_prev_q & ~stable;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stable_prev_q <= 1'b1;
         press_q       <= 1'b0;
      end else begin
         stable_prev_q <= stable;
         press_q       <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/operand_capture.sv
// Sequential operand/mode entry for the magnitude comparator: one debounced button steps A -> B -> SHOW.
// OPCAP_DB_BYPASS_EN shortens the button path to the synchronizer only (bench use).
module operand_capture
   import opcap_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic              MAX10_CLK1_50,
   input  logic              rst,
   input  logic              KEY1,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              sw_signed,
   output logic [DATA_W-1:0] input1,
   output logic [DATA_W-1:0] input2,
   output logic [MODE_W-1:0] scomp,
   output logic              valid,
   output logic [LED_W-1:0]  state_led
);

   logic press;

   key_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_key_debounce (
      .clk_i   (MAX10_CLK1_50),
      .rst_i   (rst),
      .key_n_i (KEY1),
      .press_o (press)
   );

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   in1_q, in1_d;
   logic [DATA_W-1:0]   in2_q, in2_d;
   logic [MODE_W-1:0]   scomp_q, scomp_d;
   logic                valid_q, valid_d;
   logic [LED_W-1:0]    led_q, led_d;

   // Switches are only looked at on the edge that consumes a press.
   always_comb begin
      state_d = state_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      scomp_d = scomp_q;
      valid_d = valid_q;
      if (press) begin
         case (state_q)
            WAIT_B: begin
               in2_d   = sw_data;
               scomp_d = sw_signed ? MODE_SIGNED : MODE_UNSIGNED;
               valid_d = 1'b1;
               state_d = SHOW;
            end
            default: begin
               in1_d   = sw_data;
               valid_d = 1'b0;
               state_d = WAIT_B;
            end
         endcase
      end
      led_d = state_led_f(state_d);
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (rst) begin
         state_q <= WAIT_A;
         in1_q   <= '0;
         in2_q   <= '0;
         scomp_q <= MODE_UNSIGNED;
         valid_q <= 1'b0;
         led_q   <= LED_WAIT_A;
      end else begin
         state_q <= state_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         scomp_q <= scomp_d;
         valid_q <= valid_d;
         led_q   <= led_d;
      end
   end

   assign input1    = in1_q;
   assign input2    = in2_q;
   assign scomp     = scomp_q;
   assign valid     = valid_q;
   assign state_led = led_q;

endmodule

// File: tb/tb_operand_capture.sv
// Self-checking bench for operand_capture: vector table, hand-written corner sequences, random presses vs model.
// Honors OPCAP_DB_BYPASS_EN when the design is built with it.
module tb_operand_capture;

   localparam int unsigned DB = 4;
`ifdef OPCAP_DB_BYPASS_EN
   localparam int LAT    = 3;
   localparam bit BYPASS = 1'b1;
`else
   localparam int LAT    = int'(DB) + 3;
   localparam bit BYPASS = 1'b0;
`endif
   localparam int SETTLE = 2 * int'(DB) + 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       key1;
   logic [3:0] sw_data;
   logic       sw_signed;
   logic [3:0] input1, input2;
   logic [1:0] scomp;
   logic       valid;
   logic [2:0] state_led;

   always #5 clk = ~clk;

   operand_capture #(.DB_CYCLES(DB)) dut (
      .MAX10_CLK1_50 (clk),
      .rst           (rst),
      .KEY1          (key1),
      .sw_data       (sw_data),
      .sw_signed     (sw_signed),
      .input1        (input1),
      .input2        (input2),
      .scomp         (scomp),
      .valid         (valid),
      .state_led     (state_led)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: which operand the next press fills, and the committed values.
   int         m_stage;   // 0 = expecting A, 1 = expecting B, 2 = set shown
   logic [3:0] m_a, m_b;
   logic [1:0] m_mode;
   logic       m_valid;

   function automatic logic [2:0] led_of(input int st);
      if (st == 1) return 3'b010;
      if (st == 2) return 3'b100;
      return 3'b001;
   endfunction

   task automatic model_reset();
      m_stage = 0; m_a = 4'd0; m_b = 4'd0; m_mode = 2'b10; m_valid = 1'b0;
   endtask

   task automatic model_press(input logic [3:0] d, input logic s);
      if (m_stage == 1) begin
         m_b = d; m_mode = s ? 2'b11 : 2'b10; m_valid = 1'b1; m_stage = 2;
      end else begin
         m_a = d; m_valid = 1'b0; m_stage = 1;
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".input1"},    8'(input1),    8'(m_a));
      check({tag, ".input2"},    8'(input2),    8'(m_b));
      check({tag, ".scomp"},     8'(scomp),     8'(m_mode));
      check({tag, ".valid"},     8'(valid),     8'(m_valid));
      check({tag, ".state_led"}, 8'(state_led), 8'(led_of(m_stage)));
   endtask

   // Drive a press and stop exactly on the update edge; checks nothing moved one cycle earlier.
   task automatic do_press(input string tag, input logic [3:0] d, input logic s, input bit one_cycle);
      @(negedge clk);
      sw_data = d; sw_signed = s; key1 = 1'b0;
      if (one_cycle) begin
         @(negedge clk);
         key1 = 1'b1;
         repeat (LAT - 1) @(negedge clk);
      end else begin
         repeat (LAT) @(negedge clk);
      end
      check({tag, ".early.state_led"}, 8'(state_led), 8'(led_of(m_stage)));
      check({tag, ".early.input1"},    8'(input1),    8'(m_a));
      @(negedge clk);
      model_press(d, s);
   endtask

   // Scramble switches while held and after release; nothing may change.
   task automatic finish_press(input int hold);
      sw_data = 4'($urandom); sw_signed = 1'($urandom);
      repeat (hold) @(negedge clk);
      key1 = 1'b1;
      repeat (SETTLE) @(negedge clk);
      sw_data = 4'($urandom); sw_signed = 1'($urandom);
      @(negedge clk);
   endtask

   typedef struct {
      logic [3:0] d;
      logic       s;
      logic [3:0] e1;
      logic [3:0] e2;
      logic [1:0] esc;
      logic       ev;
      logic [2:0] eled;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{d:4'h5, s:1'b0, e1:4'h5, e2:4'h0, esc:2'b10, ev:1'b0, eled:3'b010};
      vecs[1] = '{d:4'hE, s:1'b1, e1:4'h5, e2:4'hE, esc:2'b11, ev:1'b1, eled:3'b100};
      vecs[2] = '{d:4'h8, s:1'b0, e1:4'h8, e2:4'hE, esc:2'b11, ev:1'b0, eled:3'b010};
      vecs[3] = '{d:4'h3, s:1'b0, e1:4'h8, e2:4'h3, esc:2'b10, ev:1'b1, eled:3'b100};
      vecs[4] = '{d:4'hF, s:1'b1, e1:4'hF, e2:4'h3, esc:2'b10, ev:1'b0, eled:3'b010};
      vecs[5] = '{d:4'h9, s:1'b1, e1:4'hF, e2:4'h9, esc:2'b11, ev:1'b1, eled:3'b100};

      rst = 1'b1; key1 = 1'b1; sw_data = 4'h0; sw_signed = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_model("reset");

      // Vector table: each press checked against hand-derived constants on the update edge.
      for (int i = 0; i < 6; i++) begin
         do_press($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, 1'b0);
         check($sformatf("vec%0d.input1", i),    8'(input1),    8'(vecs[i].e1));
         check($sformatf("vec%0d.input2", i),    8'(input2),    8'(vecs[i].e2));
         check($sformatf("vec%0d.scomp", i),     8'(scomp),     8'(vecs[i].esc));
         check($sformatf("vec%0d.valid", i),     8'(valid),     8'(vecs[i].ev));
         check($sformatf("vec%0d.state_led", i), 8'(state_led), 8'(vecs[i].eled));
         finish_press(i * 3);
         check_model($sformatf("vec%0d.hold", i));
      end

      // Repeated short lows with one-cycle high glitches must never reach the FSM.
      if (!BYPASS) begin
         for (int r = 0; r < 5; r++) begin
            key1 = 1'b0; sw_data = 4'($urandom);
            repeat (3) @(negedge clk);
            key1 = 1'b1;
            @(negedge clk);
         end
         repeat (SETTLE) @(negedge clk);
         check_model("glitch");
      end

      // Reset mid-count in WAIT_B, key held through release.
      do_press("pre_rst", 4'h7, 1'b0, 1'b0);
      finish_press(0);
      check_model("pre_rst");
      @(negedge clk);
      key1 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      check_model("rst_mid");
      @(negedge clk);
      sw_data = 4'h6; sw_signed = 1'b0;
      rst = 1'b0;
      repeat (LAT) @(negedge clk);
      check("held_rst.early.input1", 8'(input1), 8'h00);
      check("held_rst.early.state_led", 8'(state_led), 8'h01);
      @(negedge clk);
      model_press(4'h6, 1'b0);
      check_model("held_rst");
      repeat (3 * DB) @(negedge clk);
      check_model("held_rst.once");
      finish_press(0);

`ifdef OPCAP_DB_BYPASS_EN
      do_press("bypass_1cyc", 4'hA, 1'b1, 1'b1);
      check_model("bypass_1cyc");
      finish_press(0);
`endif

      // Random presses and sub-threshold pulses against the model.
      for (int it = 0; it < 16; it++) begin
         if (!BYPASS && $urandom_range(0, 2) == 0) begin
            key1 = 1'b0; sw_data = 4'($urandom);
            repeat ($urandom_range(1, DB - 1)) @(negedge clk);
            key1 = 1'b1;
            repeat (SETTLE) @(negedge clk);
            check_model($sformatf("rnd%0d.short", it));
         end else begin
            do_press($sformatf("rnd%0d", it), 4'($urandom), 1'($urandom), 1'b0);
            check_model($sformatf("rnd%0d", it));
            finish_press(int'($urandom_range(0, 10)));
            check_model($sformatf("rnd%0d.hold", it));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
